// File: rtl/cifra_pkg.sv
// Shared definitions for the iterative AES-128 forward cipher: S-box, GF(2^8) helper,
// FSM encoding and the block-state type.
package cifra_pkg;

  localparam int NUM_RODADAS = 10;
  localparam int LARG_BLOCO  = 128;

  typedef logic [LARG_BLOCO-1:0] estado_t;

  typedef enum logic [3:0] {
    OCIOSO = 4'd0,
    RODADA = 4'd1,
    PRONTO = 4'd2
  } fsm_t;

  // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x)+7 = {~x, 3'b111}.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/rodada_cifra.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed on the last round) and AddRoundKey.
module rodada_cifra
  import cifra_pkg::*;
(
  input  estado_t estado,
  input  estado_t chave_rodada,
  input  logic    ultima,
  output estado_t resultado
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(estado[127-8*i -: 8]);
  end

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    for (genvar r = 0; r < 4; r++) begin : g_lin
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end

    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];

    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign resultado[127-8*i -: 8] = (ultima ? sr[i] : mc[i]) ^ chave_rodada[127-8*i -: 8];
  end

endmodule

// File: rtl/cifra_bloco_iterativa.sv
// Iterative AES-128 encryption engine, one round per clock, valid/ready on both sides.
// Build option CIFRA_CAPTURA_CHAVE_EN: register the key schedule on accept.
//
// state  | meaning
// OCIOSO | idle, entrada_pronta=1, waiting for a block
// RODADA | applying rounds 1..10, one per clock
// PRONTO | ciphertext on saida, waiting for saida_pronta
module cifra_bloco_iterativa
  import cifra_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entrada_valida,
  output logic          entrada_pronta,
  input  logic [127:0]  bloco,
  input  logic [1407:0] chave_expandida,
  output logic          saida_valida,
  input  logic          saida_pronta,
  output logic [127:0]  saida
);

  fsm_t          estado_q, estado_d;
  estado_t       reg_estado, resultado, chave_rodada;
  logic [3:0]    contador;
  logic          ultima, aceita;
  logic [1279:0] chaves_fonte;
  logic [127:0]  chave_k [16];

  assign aceita = entrada_valida && entrada_pronta;

`ifdef CIFRA_CAPTURA_CHAVE_EN
  // Round key 0 is consumed at the accept edge, so only keys 1..10 are held.
  logic [1279:0] chave_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chave_q <= '0;
    else if (aceita) chave_q <= chave_expandida[1279:0];
  end

  assign chaves_fonte = chave_q;
`else
  assign chaves_fonte = chave_expandida[1279:0];
`endif

  for (genvar k = 0; k < 16; k++) begin : g_chave
    if (k >= 1 && k <= NUM_RODADAS) begin : g_val
      assign chave_k[k] = chaves_fonte[1279-128*(k-1) -: 128];
    end else begin : g_nulo
      assign chave_k[k] = '0;
    end
  end

  assign chave_rodada = chave_k[contador];
  assign ultima       = (contador == 4'(NUM_RODADAS));

  rodada_cifra u_rodada (
    .estado       (reg_estado),
    .chave_rodada (chave_rodada),
    .ultima       (ultima),
    .resultado    (resultado)
  );

  always_comb begin
    estado_d       = estado_q;
    entrada_pronta = 1'b0;
    saida_valida   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        entrada_pronta = 1'b1;
        if (entrada_valida) estado_d = RODADA;
      end
      RODADA: if (ultima) estado_d = PRONTO;
      PRONTO: begin
        saida_valida = 1'b1;
        if (saida_pronta) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_estado <= '0;
      contador   <= '0;
      saida      <= '0;
    end else begin
      case (estado_q)
        OCIOSO: if (entrada_valida) begin
          reg_estado <= bloco ^ chave_expandida[1407 -: 128];
          contador   <= 4'd1;
        end
        RODADA: begin
          reg_estado <= resultado;
          if (ultima) begin
            saida    <= resultado;
            contador <= '0;
          end else begin
            contador <= contador + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cifra_bloco_iterativa.sv
// Directed bench for cifra_bloco_iterativa with an expected-ciphertext queue
// popped on every output handshake.
module tb_cifra_bloco_iterativa;
  import cifra_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          entrada_valida;
  logic          entrada_pronta;
  logic [127:0]  bloco;
  logic [1407:0] chave_expandida;
  logic          saida_valida;
  logic          saida_pronta;
  logic [127:0]  saida;

  cifra_bloco_iterativa dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entrada_valida  (entrada_valida),
    .entrada_pronta  (entrada_pronta),
    .bloco           (bloco),
    .chave_expandida (chave_expandida),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .saida           (saida)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  int            checks = 0;
  int            erros  = 0;
  int            ciclo  = 0;
  logic [127:0]  esperado [$];
  int            aceites [$];
  logic [1407:0] ks1, ks2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ciclo <= ciclo + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1407:0] expandir(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  // Sampled mid-cycle: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (entrada_valida && entrada_pronta) aceites.push_back(ciclo);
      if (saida_valida && saida_pronta) begin
        if (esperado.size() == 0) begin
          checks++;
          erros++;
          $error("FAIL saida_inesperada observed=%h expected=none", saida);
        end else begin
          chk("saida", saida, esperado.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aguardar_valida(input string tag, input int lat);
    int n;
    n = 0;
    while (!saida_valida && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 128'(n), 128'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int espaco;
    rst_n           = 1'b0;
    entrada_valida  = 1'b0;
    bloco           = '0;
    chave_expandida = '0;
    saida_pronta    = 1'b0;
    ks1 = expandir(K1);
    ks2 = expandir(K2);

    repeat (2) tick();
    chk("reset_entrada_pronta", 128'(entrada_pronta), 128'(1));
    chk("reset_saida_valida", 128'(saida_valida), 128'(0));
    chk("reset_saida", saida, 128'h0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1, latency and handshake timing
    bloco = P1; chave_expandida = ks1; entrada_valida = 1'b1;
    esperado.push_back(C1);
    tick();
    entrada_valida = 1'b0;
    chk("pronta_em_rodada", 128'(entrada_pronta), 128'(0));
    aguardar_valida("latencia_c1", 10);
    chk("saida_c1_direta", saida, C1);
    chk("pronta_em_pronto", 128'(entrada_pronta), 128'(0));
    saida_pronta = 1'b1;
    tick();
    saida_pronta = 1'b0;
    chk("valida_apos_hs", 128'(saida_valida), 128'(0));
    chk("pronta_apos_hs", 128'(entrada_pronta), 128'(1));
    chk("saida_retida", saida, C1);

    // Appendix B with backpressure and ignored extra input
    bloco = P2; chave_expandida = ks2; entrada_valida = 1'b1;
    esperado.push_back(C2);
    tick();
    entrada_valida = 1'b0;
    aguardar_valida("latencia_b", 10);
    n0 = aceites.size();
    entrada_valida = 1'b1; bloco = P1; chave_expandida = ks1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valida", 128'(saida_valida), 128'(1));
      chk("bp_saida", saida, C2);
      chk("bp_pronta", 128'(entrada_pronta), 128'(0));
      tick();
    end
    entrada_valida = 1'b0;
    chk("entrada_ignorada", 128'(aceites.size()), 128'(n0));
    saida_pronta = 1'b1;
    chk("pronta_no_hs", 128'(entrada_pronta), 128'(0));
    tick();
    saida_pronta = 1'b0;
    chk("bp_valida_fim", 128'(saida_valida), 128'(0));
    chk("bp_pronta_fim", 128'(entrada_pronta), 128'(1));
    chk("bp_fila", 128'(esperado.size()), 128'(0));

    // Back-to-back with saida_pronta tied high
    aceites.delete();
    saida_pronta = 1'b1;
    bloco = P1; chave_expandida = ks1; entrada_valida = 1'b1;
    esperado.push_back(C1);
    tick();
    aguardar_valida("latencia_b2b_1", 10);
    bloco = P2; chave_expandida = ks2;
    esperado.push_back(C2);
    tick();
    tick();
    entrada_valida = 1'b0;
    aguardar_valida("latencia_b2b_2", 10);
    tick();
    saida_pronta = 1'b0;
    espaco = (aceites.size() == 2) ? aceites[1] - aceites[0] : -1;
    chk("b2b_aceites", 128'(aceites.size()), 128'(2));
    chk("b2b_espaco", 128'(espaco), 128'(12));

    // Reset in the middle of round 5
    bloco = P1; chave_expandida = ks1; entrada_valida = 1'b1;
    esperado.push_back(C1);
    tick();
    entrada_valida = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_meio_pronta", 128'(entrada_pronta), 128'(1));
    chk("rst_meio_valida", 128'(saida_valida), 128'(0));
    chk("rst_meio_saida", saida, 128'h0);
    esperado.delete();
    tick();
    rst_n = 1'b1;
    tick();
    saida_pronta = 1'b1;
    bloco = P1; chave_expandida = ks1; entrada_valida = 1'b1;
    esperado.push_back(C1);
    tick();
    entrada_valida = 1'b0;
    aguardar_valida("latencia_pos_reset", 10);
    tick();
    saida_pronta = 1'b0;

`ifdef CIFRA_CAPTURA_CHAVE_EN
    // Captured key: schedule on the port is wiped right after accept
    bloco = P1; chave_expandida = ks1; entrada_valida = 1'b1;
    esperado.push_back(C1);
    tick();
    entrada_valida  = 1'b0;
    chave_expandida = '0;
    saida_pronta    = 1'b1;
    aguardar_valida("latencia_captura", 10);
    tick();
    saida_pronta = 1'b0;
`endif

    repeat (2) tick();
    chk("fila_final", 128'(esperado.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
